// File: rtl/muldiv_seq.sv
// Sequential RV-M style multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, one bit per cycle, with sign fix-up.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [2:0] OP_MUL = 3'b000;
  localparam logic [2:0] OP_DIV = 3'b100;
  localparam logic [2:0] OP_REM = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic                accept_s;
  logic                last_s;
  logic                special_s;
  logic [XLEN-1:0]     special_res_s;
  logic                a_neg_s, b_neg_s;
  logic [XLEN-1:0]     mag_a_s, mag_b_s;
  logic                start_neg_s;
  logic [2*XLEN-1:0]   step_s;
  logic [XLEN:0]       mul_sum_s;
  logic [XLEN:0]       rem_sh_s;
  logic                q_bit_s;
  logic [XLEN-1:0]     new_rem_s;
  logic [2*XLEN-1:0]   prod_s;
  logic [XLEN-1:0]     div_sel_s;
  logic [XLEN-1:0]     final_res_s;

  assign accept_s = start_i && !kill_i && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last_s   = (cnt_q == CW'(XLEN - 1));

  // Operand decode at accept: signedness, magnitudes, sign fix-up and special cases
  always_comb begin
    a_neg_s       = 1'b0;
    b_neg_s       = 1'b0;
    special_s     = 1'b0;
    special_res_s = {XLEN{1'b0}};
    if (op_i[2] == 1'b0) begin
      a_neg_s = (op_i[1:0] != 2'b11) && a_i[XLEN-1];
      b_neg_s = (op_i[1] == 1'b0) && b_i[XLEN-1];
    end else begin
      a_neg_s = !op_i[0] && a_i[XLEN-1];
      b_neg_s = !op_i[0] && b_i[XLEN-1];
    end
    mag_a_s = a_neg_s ? (~a_i + {{(XLEN-1){1'b0}}, 1'b1}) : a_i;
    mag_b_s = b_neg_s ? (~b_i + {{(XLEN-1){1'b0}}, 1'b1}) : b_i;
    // Remainder takes the dividend's sign; everything else takes the XOR.
    if (op_i[2] && op_i[1]) begin
      start_neg_s = a_neg_s;
    end else begin
      start_neg_s = a_neg_s ^ b_neg_s;
    end
    if (op_i[2] && (b_i == {XLEN{1'b0}})) begin
      special_s     = 1'b1;
      special_res_s = op_i[1] ? a_i : {XLEN{1'b1}};
    end else if (((op_i == OP_DIV) || (op_i == OP_REM)) &&
                 (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == {XLEN{1'b1}})) begin
      special_s     = 1'b1;
      special_res_s = op_i[1] ? {XLEN{1'b0}} : a_i;
    end else begin
      special_s     = 1'b0;
      special_res_s = {XLEN{1'b0}};
    end
  end

  // One iteration of shift-add multiply or restoring divide, plus final sign fix-up
  always_comb begin
    mul_sum_s = {1'b0, acc_q[2*XLEN-1:XLEN]} + ({1'b0, opnd_q} & {(XLEN+1){acc_q[0]}});
    rem_sh_s  = acc_q[2*XLEN-1:XLEN-1];
    q_bit_s   = (rem_sh_s >= {1'b0, opnd_q});
    new_rem_s = q_bit_s ? (rem_sh_s[XLEN-1:0] - opnd_q) : rem_sh_s[XLEN-1:0];
    if (op_q[2]) begin
      step_s = {new_rem_s, acc_q[XLEN-2:0], q_bit_s};
    end else begin
      step_s = {mul_sum_s, acc_q[XLEN-1:1]};
    end
    prod_s    = neg_q ? (~step_s + {{(2*XLEN-1){1'b0}}, 1'b1}) : step_s;
    div_sel_s = op_q[1] ? step_s[2*XLEN-1:XLEN] : step_s[XLEN-1:0];
    if (op_q[2]) begin
      final_res_s = neg_q ? (~div_sel_s + {{(XLEN-1){1'b0}}, 1'b1}) : div_sel_s;
    end else if (op_q == OP_MUL) begin
      final_res_s = prod_s[XLEN-1:0];
    end else begin
      final_res_s = prod_s[2*XLEN-1:XLEN];
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) state_d = special_s ? S_DONE : S_BUSY;
        else          state_d = S_IDLE;
      end
      S_BUSY: begin
        if (kill_i)      state_d = S_IDLE;
        else if (last_s) state_d = S_DONE;
        else             state_d = S_BUSY;
      end
      S_DONE: begin
        if (accept_s) state_d = special_s ? S_DONE : S_BUSY;
        else          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    busy_d   = (state_d == S_BUSY);
    valid_d  = (state_d == S_DONE);
    result_d = result_q;
    op_d     = op_q;
    neg_d    = neg_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (accept_s) begin
      op_d   = op_i;
      neg_d  = start_neg_s;
      opnd_d = mag_b_s;
      acc_d  = {{XLEN{1'b0}}, mag_a_s};
      cnt_d  = {CW{1'b0}};
      if (special_s) result_d = special_res_s;
      else           result_d = result_q;
    end else if ((state_q == S_BUSY) && !kill_i) begin
      acc_d = step_s;
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
      if (last_s) result_d = final_res_s;
      else        result_d = result_q;
    end else begin
      result_d = result_q;
    end
  end

  // State, outputs and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= {XLEN{1'b0}};
      op_q     <= 3'b000;
      neg_q    <= 1'b0;
      opnd_q   <= {XLEN{1'b0}};
      acc_q    <= {(2*XLEN){1'b0}};
      cnt_q    <= {CW{1'b0}};
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy_o   = busy_q;
  assign valid_o  = valid_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq (XLEN=32): hand-computed results, latencies,
// special cases, kill/start interplay, back-to-back issue and mid-op reset.
module tb_muldiv_seq;
  localparam int XLEN = 32;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  logic            clk = 1'b0;
  logic            rst, start, kill;
  logic [2:0]      op;
  logic [XLEN-1:0] a, b;
  logic            busy, valid;
  logic [XLEN-1:0] result;

  int total = 0;
  int bad   = 0;

  muldiv_seq #(.XLEN(XLEN)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .kill_i(kill), .op_i(op),
    .a_i(a), .b_i(b), .busy_o(busy), .valid_o(valid), .result_o(result)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Called #1 after the accept edge; lat counts from the accept cycle (1 = next cycle).
  task automatic wait_valid(output int lat, output int nb);
    lat = 1;
    nb  = 0;
    for (int i = 0; i < 200; i++) begin
      if (valid) return;
      if (busy) nb++;
      @(posedge clk); #1;
      lat++;
    end
    lat = -1;
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
    int lat, nb;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_valid(lat, nb);
    check_val({tag, "_res"}, result, exp);
    check_val({tag, "_lat"}, lat, exp_lat);
    check_val({tag, "_busy"}, nb, exp_lat - 1);
    @(posedge clk); #1;
    check_val({tag, "_pulse"}, valid, 1'b0);
  endtask

  initial begin
    int lat, nb, vcnt;
    rst = 1'b1; start = 1'b0; kill = 1'b0; op = 3'b000; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_valid", valid, 1'b0);
    check_val("rst_result", result, 32'h0);
    repeat (5) @(posedge clk);
    #1;
    check_val("idle_valid", valid, 1'b0);
    check_val("idle_result", result, 32'h0);

    run_op("mul",     OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run_op("mulh",    OP_MULH,   32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 33);
    run_op("mulhsu",  OP_MULHSU, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 33);
    run_op("mulhu",   OP_MULHU,  32'h8000_0000,  32'hFFFF_FFFF, 32'h7FFF_FFFF, 33);
    run_op("div",     OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
    run_op("rem",     OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
    run_op("divu",    OP_DIVU,   32'd100,        32'd7,         32'd14,        33);
    run_op("remu",    OP_REMU,   32'd100,        32'd7,         32'd2,         33);
    run_op("div0",    OP_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1);
    run_op("remu0",   OP_REMU,   32'd5,          32'd0,         32'd5,         1);
    run_op("divovf",  OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("removf",  OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1);
    run_op("divu_big", OP_DIVU,  32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         33);
    run_op("remu_big", OP_REMU,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 33);
    run_op("remu_pre", OP_REMU,  32'd100,        32'd7,         32'd2,         33);

    // Ignored start mid-BUSY, then kill: no valid, result untouched.
    op = OP_MUL; a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    vcnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (valid) vcnt++;
      if (k == 9)  begin start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7; end
      if (k == 10) start = 1'b0;
      if (k == 19) kill = 1'b1;
      @(posedge clk); #1;
    end
    kill = 1'b0;
    check_val("kill_busy", busy, 1'b0);
    for (int k = 0; k < 40; k++) begin
      if (valid) vcnt++;
      @(posedge clk); #1;
    end
    check_val("kill_novalid", vcnt, 0);
    check_val("kill_result", result, 32'd2);
    run_op("divu_after", OP_DIVU, 32'd9, 32'd3, 32'd3, 33);

    // kill in DONE beats a simultaneous start.
    op = OP_MUL; a = 32'd6; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_valid(lat, nb);
    check_val("kdone_res", result, 32'd42);
    start = 1'b1; kill = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    check_val("kdone_busy", busy, 1'b0);
    check_val("kdone_valid", valid, 1'b0);
    // kill in IDLE also blocks start.
    start = 1'b1; kill = 1'b1; op = OP_DIV; a = 32'd5; b = 32'd0;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    check_val("kidle_valid", valid, 1'b0);
    check_val("kidle_result", result, 32'd42);

    // Back-to-back: start held through BUSY and DONE; operands changed mid-op are ignored.
    op = OP_MULHU; a = 32'h8000_0000; b = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    a = 32'h1234; b = 32'h5678;
    wait_valid(lat, nb);
    check_val("b2b1_res", result, 32'h7FFF_FFFF);
    check_val("b2b1_lat", lat + 3, 33);
    op = OP_DIVU; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    wait_valid(lat, nb);
    check_val("b2b2_res", result, 32'd14);
    check_val("b2b2_lat", lat, 33);

    // Reset mid-BUSY.
    @(posedge clk); #1;
    op = OP_MUL; a = 32'd7; b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("mrst_busy", busy, 1'b0);
    check_val("mrst_valid", valid, 1'b0);
    check_val("mrst_result", result, 32'h0);
    vcnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (valid) vcnt++;
      @(posedge clk); #1;
    end
    check_val("mrst_novalid", vcnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; SHALL support any even value 8..64.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE or DONE.
REQ-005 kill  input  1  abort of the in-flight operation (pipeline flush).
REQ-006 op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 a  input  XLEN  rs1 operand, captured on accepted start.
REQ-008 b  input  XLEN  rs2 operand, captured on accepted start.
REQ-009 busy  output  1  high while in BUSY.
REQ-010 valid  output  1  one-cycle pulse, result ready.
REQ-011 result  output  XLEN  result; held stable from valid until the next accepted start.

Function
REQ-012 States SHALL be IDLE, BUSY and DONE; busy=1 only in BUSY; valid=1 only in DONE.
REQ-013 Start SHALL be accepted when start=1 in IDLE or DONE. On acceptance the block latches op, a and b, then enters BUSY, or enters DONE for a special case.
REQ-014 Start in BUSY SHALL be ignored, and the operands SHALL NOT be recaptured.
REQ-015 BUSY SHALL last exactly XLEN cycles, driven by an iteration counter of width clog2(XLEN)+1. DONE is entered on the cycle after the last iteration.
REQ-016 Normal latency: accept edge, then XLEN BUSY cycles, then valid; valid is asserted XLEN+1 cycles after the accept edge.
REQ-017 DONE SHALL last one cycle. The next state is BUSY (or DONE) if start=1, otherwise IDLE.
REQ-018 Multiply SHALL be iterative radix-2 shift-add on operand magnitudes into a 2*XLEN accumulator. The final sign correction is two's-complement negation of the full 2*XLEN product.
REQ-019 Signedness: MUL/MULH use a and b signed; MULHSU uses a signed and b unsigned; MULHU uses both unsigned.
REQ-020 MUL SHALL return product[XLEN-1:0]; MULH, MULHSU and MULHU SHALL return product[2*XLEN-1:XLEN].
REQ-021 Divide SHALL be iterative restoring division, one quotient bit per cycle, on magnitudes. Signed DIV/REM operate on magnitudes.
REQ-022 DIV quotient sign SHALL be sign(a) XOR sign(b); REM remainder sign SHALL equal sign(a), truncating toward zero.
REQ-023 Divide by zero (b=0), for all of DIV, DIVU, REM and REMU, SHALL skip BUSY with valid on the cycle after accept:
- DIV and DIVU return all-ones.
- REM and REMU return a.
REQ-024 Signed overflow (DIV or REM with a=-2^(XLEN-1) and b=-1) SHALL skip BUSY:
- DIV returns a.
- REM returns 0.
REQ-025 Multiplies SHALL NOT have an early-out; latency is fixed at XLEN+1.
REQ-026 kill=1 in BUSY SHALL return the block to IDLE on the next edge, with no valid pulse and result unchanged.
REQ-027 kill=1 in DONE SHALL suppress acceptance of a simultaneous start and return to IDLE; the valid pulse of that cycle still stands.
REQ-028 kill=1 in IDLE SHALL have no effect, and kill has priority over start in every state.
REQ-029 result SHALL update only on the edge entering DONE.

Reset
REQ-030 rst=1 SHALL force IDLE and set busy=0, valid=0, result=0, the counter to 0 and the operand/accumulator registers to 0 on the next rising edge.
REQ-031 rst SHALL have priority over start and kill; rst during BUSY SHALL abort the operation with no valid pulse.
REQ-032 With no start after reset, outputs SHALL stay at their reset values indefinitely.

Verification
REQ-033 XLEN=32, op=MUL, a=7, b=-3:
- busy for 32 cycles.
- valid exactly 33 cycles after the accept edge.
- result=0xFFFFFFEB.
REQ-034 XLEN=32, MULH, MULHSU and MULHU with a=0x80000000, b=0xFFFFFFFF:
- MULH returns 0x00000000.
- MULHSU returns 0x80000000.
- MULHU returns 0x7FFFFFFF.
REQ-035 DIV a=-7, b=2 -> result=-3 (0xFFFFFFFD); REM with the same operands -> result=-1; DIVU a=100, b=7 -> result=14; REMU with the same operands -> result=2.
REQ-036 Divide by zero and signed overflow, each with valid 1 cycle after accept and busy never asserted:
- DIV a=5, b=0 -> 0xFFFFFFFF.
- REMU a=5, b=0 -> 5.
- DIV a=0x80000000, b=-1 -> 0x80000000.
- REM with the same operands -> 0.
REQ-037 Start MUL, then start again at BUSY cycle 10 with different operands; assert kill at BUSY cycle 20:
- The second start is ignored.
- No valid pulse occurs and result is unchanged.
- A following DIVU 9/3 returns 3.
REQ-038 Back-to-back: start held high through DONE -> the second op is accepted in the DONE cycle and its valid follows XLEN+1 cycles later. rst pulsed mid-BUSY -> next cycle busy=0, valid=0, result=0.
